// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath blocks: controller state encoding.
package rsa_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rsa_half_mod_step.sv
// One modular halving step: (acc + acc[0]*N) >> 1, exact because N is odd.
module rsa_half_mod_step #(
  parameter int MOD_WIDTH = 256
) (
  input  logic [MOD_WIDTH-1:0] acc,
  input  logic [MOD_WIDTH-1:0] modulus,
  output logic [MOD_WIDTH-1:0] half
);

  logic [MOD_WIDTH-1:0] addend;

  assign addend = acc[0] ? modulus : '0;

  // Bits [MOD_WIDTH:1] of the full (MOD_WIDTH+1)-bit sum: the upper bits are
  // added directly and bit 0 contributes only its carry, so the top carry is kept.
  assign half = {1'b0, acc[MOD_WIDTH-1:1]}
              + {1'b0, addend[MOD_WIDTH-1:1]}
              + {{(MOD_WIDTH-1){1'b0}}, acc[0] & addend[0]};

endmodule

// File: rtl/rsa_two_power_inv_mod.sv
// Computes value * 2^(-k) mod N (N odd) by repeated modular halving.
// Define RSA_TWO_POWER_INV_MOD_RADIX4_EN to apply two halvings per cycle.
module rsa_two_power_inv_mod
  import rsa_pkg::*;
#(
  parameter int MOD_WIDTH   = 256,
  parameter int POWER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [MOD_WIDTH-1:0]   i_value,
  input  logic [MOD_WIDTH-1:0]   i_modulus,
  input  logic [POWER_WIDTH-1:0] i_power,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [MOD_WIDTH-1:0]   o_out
);

  state_t                 state, state_next;
  logic [MOD_WIDTH-1:0]   acc, modulus, step1;
  logic [POWER_WIDTH-1:0] power, cnt, remaining;
  logic                   accept, last_step;

  assign accept    = (state == IDLE) && i_valid;
  assign remaining = power - cnt;

  rsa_half_mod_step #(.MOD_WIDTH(MOD_WIDTH)) u_step1 (
    .acc     (acc),
    .modulus (modulus),
    .half    (step1)
  );

`ifdef RSA_TWO_POWER_INV_MOD_RADIX4_EN
  logic [MOD_WIDTH-1:0] step2;

  rsa_half_mod_step #(.MOD_WIDTH(MOD_WIDTH)) u_step2 (
    .acc     (step1),
    .modulus (modulus),
    .half    (step2)
  );

  assign last_step = remaining <= POWER_WIDTH'(2);
`else
  assign last_step = remaining == POWER_WIDTH'(1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_valid) state_next = (i_power == '0) ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (o_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured on accept and held through DONE so o_out stays stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      modulus <= '0;
      power   <= '0;
      cnt     <= '0;
    end else if (accept) begin
      acc     <= i_value;
      modulus <= i_modulus;
      power   <= i_power;
      cnt     <= '0;
    end else if (state == CALC) begin
`ifdef RSA_TWO_POWER_INV_MOD_RADIX4_EN
      if (remaining == POWER_WIDTH'(1)) begin
        acc <= step1;
        cnt <= cnt + POWER_WIDTH'(1);
      end else begin
        acc <= step2;
        cnt <= cnt + POWER_WIDTH'(2);
      end
`else
      acc <= step1;
      cnt <= cnt + POWER_WIDTH'(1);
`endif
    end
  end

  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_out   = acc;

endmodule

// File: doc/rsa_two_power_inv_mod.md
# rsa_two_power_inv_mod

Computes o_out = i_value · 2^(−i_power) mod i_modulus for odd modulus by repeated conditional-add-and-halve (Montgomery-style reduction), one exponent bit per cycle. It is the inverse-direction companion to the two-power-mod block: that block produces 2^k mod N to bring operands into the Montgomery domain, and this block removes the 2^k factor on the way out. It sits at the output of the RSA datapath and uses the same valid/ready handshake on both sides.

## Interface
- MOD_WIDTH, 256, modulus/operand width in bits
- POWER_WIDTH, 32, exponent width in bits
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- i_valid  input  1  request valid
- i_ready  output  1  block idle, can accept a request
- i_value  input  MOD_WIDTH  operand; caller guarantees i_value < i_modulus
- i_modulus  input  MOD_WIDTH  N; caller guarantees N odd, N > 1
- i_power  input  POWER_WIDTH  k, number of halvings
- o_valid  output  1  result valid
- o_ready  input  1  consumer accepts result
- o_out  output  MOD_WIDTH  result, registered

## Operation
- States: IDLE, CALC, DONE. Encoding 2 bits; unused codes return to IDLE.
- IDLE: i_ready=1. On i_valid: latch N, k, acc←i_value, cnt←0; go to CALC if k≠0, else DONE.
- CALC: each cycle acc←(acc + (acc[0] ? N : 0)) >> 1, cnt←cnt+1; when cnt==k−1 (after this step) go to DONE.
- Sum computed at MOD_WIDTH+1 bits; carry bit kept before shift. Invariant acc < N holds every cycle, so no final subtraction.
- DONE: o_valid=1, o_out=acc; acc, N, k held. On o_ready go to IDLE.
- Inputs ignored when i_ready=0; o_ready ignored outside DONE.
- Next-state logic holds state by default; no latches.
- Out-of-contract inputs (even N, i_value ≥ N): result undefined, handshake still completes in the same cycle count.

## Timing
- Reset: state=IDLE, i_ready=1, o_valid=0, o_out=0, acc/N/k/cnt=0.
- Accept edge E0 (i_valid & i_ready). o_valid rises after edge E_p, p = k (k=0: after E0 itself). Throughput: one request per p+2 cycles minimum with o_ready held high.
- Handshake completes at edge where o_valid & o_ready; i_ready rises the following cycle (no same-cycle accept from DONE).
- o_valid & !o_ready: o_out, o_valid stable indefinitely.
- k = 2^POWER_WIDTH−1: cnt does not wrap before match; exactly k steps.
- Reset mid-CALC or mid-DONE: immediate return to reset values; no output pulse.

## Configuration
- RSA_TWO_POWER_INV_MOD_RADIX4_EN defined: CALC applies two chained halving steps per cycle; p = ceil(k/2); when k odd the final CALC cycle applies one step only; counter advances by 2. Result identical to radix-2.
- Undefined: one step per cycle, p = k.

## Structure
- Shared package rsa_pkg: state enum typedef (IDLE/CALC/DONE), state-width constant.
- Sub-module rsa_half_mod_step: combinational acc, N → (acc + acc[0]·N) >> 1, parameterized MOD_WIDTH; instantiated once, or twice chained under the radix-4 macro.
- Top holds FSM, counter, operand registers.

## Test plan
- N=13, value=1, k=4, o_ready=1 -> o_out=9; o_valid after 4 edges past accept (radix-4: 2).
- N=13, value=7, k=0 -> o_out=7, o_valid the cycle after accept.
- Round trip: two-power-mod with N=13, k=5 gives 6; feed value=6, k=5 -> o_out=1. N=13, value=1, k=3 -> 5 (radix-4: 2 cycles, odd tail).
- Backpressure: o_ready low 5 cycles in DONE -> o_out, o_valid stable, i_ready=0, i_valid pulses ignored; release -> i_ready=1 next cycle.
- Reset asserted 3 cycles into k=100 job -> o_valid=0, o_out=0, i_ready=1 immediately; next job N=13, value=1, k=4 -> 9.
- 1000 random 256-bit odd N, value<N, k in 0..600 against software model; back-to-back requests with random o_ready.
